window_addr_gen: RTL and testbench

Parametrised read/write address sequencer for the masked 2D WOS filter. It scans an image of runtime size img_h x img_w in raster order with a runtime rectangular kernel of k_h x k_w taps, and emits one kernel column per output step for the sliding-window datapath. It handles borders (skip or replicate), stalls and a start/done handshake, and drives the pixel RAM read port and the result RAM write port.

---
 rtl/window_addr_gen.sv | 201 ++++++++++++++++++++
 tb/tb_window_addr_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// window_addr_gen: raster tap/address sequencer for the masked 2D WOS filter.
// Emits one kernel column of read taps per output step plus result writes.
module window_addr_gen #(
  parameter int DIM_W   = 9,
  parameter int ADDR_W  = 10,
  parameter int MAX_K   = 25,
  parameter int W_DELAY = 2,
  localparam int KW     = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [KW-1:0]     k_h,
  input  logic [KW-1:0]     k_w,
  input  logic              pad_mode,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_en,
  output logic              r_oob,
  output logic              col_last,
  output logic              row_start,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic              busy,
  output logic              done
);

  localparam int SW = DIM_W + 2;
  localparam int DW = $clog2(W_DELAY + 1);
  localparam logic signed [SW-1:0] ONE = 1;

  typedef enum logic [2:0] {
    IDLE, RUN, ROW_END, DRAIN, DONE
  } state_t;

  state_t state;

  logic [DIM_W-1:0] h_q, w_q, y;
  logic [KW-1:0]    ry_q, rx_q;
  logic             pad_q;
  logic signed [SW-1:0] xc, dy;
  logic [DW-1:0]    dcnt;
  logic [W_DELAY-1:0] pv;
  logic [ADDR_W-1:0]  pa [W_DELAY];

  logic signed [SW-1:0] h_s, w_s, y_s, rx_s, ry_s;
  logic signed [SW-1:0] yc, cy, cx, xo;
  logic [KW-1:0]    rx_in, ry_in;
  logic [ADDR_W-1:0] ra, wa;
  logic oob, col_end, x_last, first, push, halt;

  assign h_s  = $signed(SW'(h_q));
  assign w_s  = $signed(SW'(w_q));
  assign y_s  = $signed(SW'(y));
  assign rx_s = $signed(SW'(rx_q));
  assign ry_s = $signed(SW'(ry_q));

  assign rx_in = k_w >> 1;
  assign ry_in = k_h >> 1;

  assign yc  = y_s + dy;
  assign oob = yc[SW-1] || (yc >= h_s) ||
               xc[SW-1] || (xc >= w_s);

  // Clamping is the identity for in-image taps.
  assign cy = yc[SW-1] ? '0 :
              (yc >= h_s) ? h_s - ONE : yc;
  assign cx = xc[SW-1] ? '0 :
              (xc >= w_s) ? w_s - ONE : xc;

  assign ra = (pad_q || !oob) ?
              ADDR_W'(cy) * ADDR_W'(w_s) + ADDR_W'(cx) :
              '0;

  assign col_end = (dy == ry_s);
  assign x_last  = (xc == w_s - ONE + rx_s);
  assign first   = (xc == -rx_s) && (dy == -ry_s);
  assign xo      = xc - rx_s;
  assign push    = (state == RUN) && col_end && !xo[SW-1];
  assign wa      = ADDR_W'(y_s) * ADDR_W'(w_s) + ADDR_W'(xo);

  assign halt = stall &&
    (state == RUN || state == ROW_END || state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      h_q       <= '0;
      w_q       <= '0;
      ry_q      <= '0;
      rx_q      <= '0;
      pad_q     <= 1'b0;
      y         <= '0;
      xc        <= '0;
      dy        <= '0;
      dcnt      <= '0;
      pv        <= '0;
      for (int i = 0; i < W_DELAY; i++)
        pa[i] <= '0;
      r_addr    <= '0;
      r_en      <= 1'b0;
      r_oob     <= 1'b0;
      col_last  <= 1'b0;
      row_start <= 1'b0;
      w_addr    <= '0;
      w_en      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_addr    <= '0;
      r_en      <= 1'b0;
      r_oob     <= 1'b0;
      col_last  <= 1'b0;
      row_start <= 1'b0;
      w_en      <= 1'b0;
      done      <= 1'b0;

      if (!halt) begin
        pv[0] <= push;
        pa[0] <= wa;
        for (int i = 1; i < W_DELAY; i++) begin
          pv[i] <= pv[i-1];
          pa[i] <= pa[i-1];
        end
        w_en   <= pv[W_DELAY-1];
        w_addr <= pa[W_DELAY-1];
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            h_q   <= img_h;
            w_q   <= img_w;
            ry_q  <= ry_in;
            rx_q  <= rx_in;
            pad_q <= pad_mode;
            y     <= '0;
            xc    <= -$signed(SW'(rx_in));
            dy    <= -$signed(SW'(ry_in));
            if (img_h == '0 || img_w == '0)
              state <= DONE;
            else
              state <= RUN;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (!halt) begin
            r_en      <= pad_q || !oob;
            r_oob     <= oob;
            r_addr    <= ra;
            col_last  <= col_end;
            row_start <= first;
            if (col_end) begin
              dy <= -ry_s;
              if (x_last)
                state <= ROW_END;
              else
                xc <= xc + ONE;
            end else begin
              dy <= dy + ONE;
            end
          end
        end
        ROW_END: begin
          if (!halt) begin
            xc <= -rx_s;
            if (y == h_q - DIM_W'(1)) begin
              state <= DRAIN;
              dcnt  <= '0;
            end else begin
              y     <= y + DIM_W'(1);
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (!halt) begin
            if (dcnt == DW'(W_DELAY - 1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end
        end
        DONE: begin
          // Normal frames pulse done on entry; empty frames pulse here.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= !done;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: randomized frames checked against a loop-level model
// of the kernel tap scan and the raster result writes.
module tb_window_addr_gen;

  localparam int DIM_W   = 9;
  localparam int ADDR_W  = 10;
  localparam int MAX_K   = 25;
  localparam int W_DELAY = 2;
  localparam int KW      = $clog2(MAX_K + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              pad_mode = 1'b0;
  logic [DIM_W-1:0]  img_h = '0;
  logic [DIM_W-1:0]  img_w = '0;
  logic [KW-1:0]     k_h = '0;
  logic [KW-1:0]     k_w = '0;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic r_en, r_oob, col_last, row_start, w_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_t[$];
  int dut_t[$];
  int dut_w[$];

  always #5 clk = ~clk;

  window_addr_gen #(
    .DIM_W(DIM_W), .ADDR_W(ADDR_W),
    .MAX_K(MAX_K), .W_DELAY(W_DELAY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .img_h(img_h), .img_w(img_w), .k_h(k_h), .k_w(k_w),
    .pad_mode(pad_mode),
    .r_addr(r_addr), .r_en(r_en), .r_oob(r_oob),
    .col_last(col_last), .row_start(row_start),
    .w_addr(w_addr), .w_en(w_en), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every tap of the frame in scan order, straight from the scan rules.
  task automatic model(input int h, input int w,
                       input int kh, input int kw, input bit pad);
    int ry, rx, yc, cy, cx;
    bit oob, en;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W+3:0] v;
    ry = kh / 2;
    rx = kw / 2;
    exp_t.delete();
    if (h == 0 || w == 0) return;
    for (int y = 0; y < h; y++)
      for (int xc = -rx; xc <= w - 1 + rx; xc++)
        for (int d = -ry; d <= ry; d++) begin
          yc  = y + d;
          oob = (yc < 0) || (yc >= h) || (xc < 0) || (xc >= w);
          cy  = (yc < 0) ? 0 : (yc >= h) ? h - 1 : yc;
          cx  = (xc < 0) ? 0 : (xc >= w) ? w - 1 : xc;
          en  = !oob || pad;
          a   = en ? ADDR_W'(cy * w + cx) : '0;
          v   = {en, oob, d == ry, (xc == -rx) && (d == -ry), a};
          exp_t.push_back(int'(v));
        end
  endtask

  task automatic run_frame(input int h, input int w,
                           input int kh, input int kw, input bit pad,
                           input int spct, input int burst,
                           input bit poke);
    int k, s_cnt, base, ry, rx, f0;
    bit got_done, st;
    logic [ADDR_W+3:0] v;
    ry = kh / 2;
    rx = kw / 2;
    model(h, w, kh, kw, pad);
    base = (h == 0 || w == 0) ? 1 :
           h * ((w + 2 * rx) * (2 * ry + 1) + 1) + W_DELAY;
    dut_t.delete();
    dut_w.delete();
    @(negedge clk);
    img_h = DIM_W'(h);
    img_w = DIM_W'(w);
    k_h = KW'(kh);
    k_w = KW'(kw);
    pad_mode = pad;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    s_cnt = 0;
    got_done = 1'b0;
    st = 1'b0;
    while (!got_done && k < 5000) begin
      @(negedge clk);
      k++;
      if (st)
        chk("stall_quiet", int'({r_en, w_en, col_last, row_start}), 0);
      if (k == 1 && base > 1)
        chk("busy_on", int'(busy), 1);
      if (r_en || r_oob) begin
        v = {r_en, r_oob, col_last, row_start, r_addr};
        dut_t.push_back(int'(v));
      end
      if (w_en)
        dut_w.push_back(int'(w_addr));
      if (done) begin
        got_done = 1'b1;
        chk("busy_off", int'(busy), 0);
      end
      st = !done && (($urandom_range(99) < spct) ||
                     (k >= burst && k < burst + 3));
      stall = st;
      s_cnt += int'(st);
      if (poke) begin
        start = (k == 8);
        img_w = (k >= 8 && k < 12) ? DIM_W'(w + 3) : DIM_W'(w);
        k_w   = (k >= 8 && k < 12) ? KW'(kw + 2) : KW'(kw);
      end
    end
    stall = 1'b0;
    start = 1'b0;
    chk("done_seen", int'(got_done), 1);
    chk("done_cyc", k, base + s_cnt);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("ntaps", dut_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < dut_t.size(); i++) begin
      f0 = n_fail;
      chk("tap_seq", dut_t[i], exp_t[i]);
      if (n_fail != f0) break;
    end
    chk("nwr", dut_w.size(), (h == 0 || w == 0) ? 0 : h * w);
    for (int i = 0; i < dut_w.size(); i++) begin
      f0 = n_fail;
      chk("wr_seq", dut_w[i], i % (1 << ADDR_W));
      if (n_fail != f0) break;
    end
  endtask

  initial begin
    #1;
    chk("reset_state", int'({r_addr, r_en, r_oob, col_last, row_start,
                             w_addr, w_en, busy, done}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame(3, 3, 3, 3, 1'b0, 0, 9999, 1'b0);
    run_frame(3, 3, 3, 3, 1'b1, 0, 9999, 1'b0);
    run_frame(2, 4, 1, 5, 1'b0, 0, 9999, 1'b0);
    run_frame(3, 3, 3, 3, 1'b0, 0, 20, 1'b0);
    run_frame(4, 5, 3, 3, 1'b1, 0, 9999, 1'b1);
    run_frame(3, 0, 3, 3, 1'b0, 0, 9999, 1'b0);
    run_frame(0, 4, 3, 3, 1'b1, 0, 9999, 1'b0);

    // Abort a frame with reset; outputs must clear without waiting a clock.
    @(negedge clk);
    img_h = DIM_W'(5);
    img_w = DIM_W'(5);
    k_h = KW'(3);
    k_w = KW'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_out", int'({r_addr, r_en, r_oob, col_last, row_start,
                         w_addr, w_en, busy, done}), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", int'({r_en, w_en, busy, done}), 0);
    end
    rst = 1'b1;
    run_frame(3, 4, 3, 2, 1'b0, 0, 9999, 1'b0);

    for (int n = 0; n < 20; n++)
      run_frame($urandom_range(0, 6), $urandom_range(0, 7),
                $urandom_range(0, 9), $urandom_range(0, 9),
                1'($urandom_range(0, 1)),
                (n % 2 == 0) ? 0 : 25,
                $urandom_range(2, 40), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
